// File: rtl/t_ff_mod_counter.sv
// rtl/t_ff_mod_counter.sv - modulo-N up/down counter built from per-bit T flip-flop cells
// Optional feature macro: GRAY_OUT_EN (adds registered Gray-code output port gray)
module t_ff_mod_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] tog,
   output logic             tc
`ifdef GRAY_OUT_EN
   ,
   output logic [WIDTH-1:0] gray
`endif
);

   // Refuse to build with a modulus the counter cannot represent
   if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("t_ff_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] load_eff;
   logic             at_top;
   logic             at_bottom;

   assign at_top    = (q == MAX_VAL);
   assign at_bottom = (q == '0);

   // Out-of-range load values clamp to the top of the count range
   assign load_eff = (load_val > MAX_VAL) ? MAX_VAL : load_val;

   // Counting next state and the toggle vector that realises it
   always_comb begin
      q_next = q;
      if (en) begin
         if (up_dn) begin
            q_next = at_top ? '0 : q + WIDTH'(1);
         end else begin
            q_next = at_bottom ? MAX_VAL : q - WIDTH'(1);
         end
      end
      // Reset and load bypass the toggle cells, so no toggles are requested
      if (rst || load) begin
         tog = '0;
      end else begin
         tog = q ^ q_next;
      end
   end

   // Terminal count flags the cycle right before a wrap edge
   assign tc = en & ~load & ~rst & (up_dn ? at_top : at_bottom);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      // One T flip-flop cell per bit, with parallel-load bypass
      always_ff @(posedge clk) begin
         if (rst) begin
            q[i] <= 1'b0;
         end else if (load) begin
            q[i] <= load_eff[i];
         end else begin
            q[i] <= q[i] ^ tog[i];
         end
      end
   end

`ifdef GRAY_OUT_EN
   logic [WIDTH-1:0] q_d;

   // Value q takes at the next edge, whichever path produces it
   always_comb begin
      q_d = q ^ tog;
      if (rst) begin
         q_d = '0;
      end else if (load) begin
         q_d = load_eff;
      end
   end

   // Gray register tracks q so gray == q ^ (q >> 1) on every cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         gray <= '0;
      end else begin
         gray <= q_d ^ (q_d >> 1);
      end
   end
`endif

endmodule

// File: tb/tb_t_ff_mod_counter.sv
// tb/tb_t_ff_mod_counter.sv - self-checking bench for t_ff_mod_counter
module tb_t_ff_mod_counter;

   localparam int WIDTH   = 4;
   localparam int MODULUS = 10;

   logic             clk;
   logic             rst;
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] tog;
   logic             tc;
`ifdef GRAY_OUT_EN
   logic [WIDTH-1:0] gray;
`endif

   int vectors;
   int miscompares;
   int model;
   bit model_valid;

   t_ff_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .tog      (tog),
      .tc       (tc)
`ifdef GRAY_OUT_EN
      ,
      .gray     (gray)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: next count from the behavioural rules using integer arithmetic
   function automatic int next_count(input int cur, input bit r, input bit e, input bit u,
                                     input bit l, input int lv);
      if (r) return 0;
      if (l) return (lv > MODULUS - 1) ? MODULUS - 1 : lv;
      if (!e) return cur;
      if (u) return (cur + 1) % MODULUS;
      return (cur + MODULUS - 1) % MODULUS;
   endfunction

   // Apply one cycle of inputs, check combinational outputs, then the registered count
   task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv);
      int nxt;
      int exp_tog;
      bit exp_tc;
      rst      = r;
      en       = e;
      up_dn    = u;
      load     = l;
      load_val = WIDTH'(lv);
      #1;
      if (model_valid) begin
         nxt     = next_count(model, r, e, u, l, lv);
         exp_tog = (r || l) ? 0 : (model ^ nxt);
         exp_tc  = e && !l && !r && (u ? (model == MODULUS - 1) : (model == 0));
         check("tog", 8'(tog), 8'(exp_tog));
         check("tc", 8'(tc), 8'(exp_tc));
      end
      @(posedge clk);
      model       = next_count(model, r, e, u, l, lv);
      model_valid = model_valid || r;
      @(negedge clk);
      if (model_valid) begin
         check("q", 8'(q), 8'(model));
`ifdef GRAY_OUT_EN
         check("gray", 8'(gray), 8'(model ^ (model >> 1)));
`endif
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      model       = 0;
      model_valid = 1'b0;
      rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;

      // Reset and hold
      step(1, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
      check("hold_q_zero", 8'(q), 8'd0);

      // Up count through a wrap: ends at 2
      for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);
      check("up_end_q", 8'(q), 8'd2);

      // Down count through a wrap: ends at 8
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
      check("down_end_q", 8'(q), 8'd8);

      // Explicit terminal-count / toggle at the top of the range
      step(0, 1, 1, 1, 9);
      up_dn = 1'b1; en = 1'b1; load = 1'b0; rst = 1'b0;
      #1;
      check("tog_at_9", 8'(tog), 8'b1001);
      check("tc_at_9", 8'(tc), 8'd1);
      step(0, 1, 1, 0, 0);

      // Load and clamp
      step(0, 1, 1, 1, 7);
      check("load7_q", 8'(q), 8'd7);
      step(0, 1, 0, 1, 12);
      check("clamp_q", 8'(q), 8'd9);
      step(0, 0, 1, 1, 3);
      check("load_en0_q", 8'(q), 8'd3);
      step(0, 0, 1, 1, 15);

      // Reset mid-count with load and enable asserted
      step(0, 0, 1, 1, 5);
      step(1, 1, 1, 1, 7);
      check("rst_mid_q", 8'(q), 8'd0);
      step(0, 1, 1, 0, 0);
      check("post_rst_q", 8'(q), 8'd1);

      // Randomised traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
              $urandom_range(0, 1), ($urandom_range(0, 9) == 0),
              int'($urandom_range(0, 15)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
